// File: rtl/car_pkg.sv
// Shared command codes, state encoding and drive mapping for the car drive path.
package car_pkg;

    localparam logic [2:0] CMD_NONE  = 3'd0;
    localparam logic [2:0] CMD_TRACK = 3'd1;
    localparam logic [2:0] CMD_MUSIC = 3'd2;
    localparam logic [2:0] CMD_FWD   = 3'd3;
    localparam logic [2:0] CMD_BACK  = 3'd4;
    localparam logic [2:0] CMD_LEFT  = 3'd5;
    localparam logic [2:0] CMD_RIGHT = 3'd6;
    localparam logic [2:0] CMD_STOP  = 3'd7;

    localparam int ENTRY_CYCLES_DEF = 25_000_000;
    localparam int STOP_CYCLES_DEF  = 2_500_000;
    localparam int CNT_W_DEF        = 25;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_MANUAL   = 3'd1,
        ST_DEADTIME = 3'd2,
        ST_ENTRY    = 3'd3,
        ST_TRACK    = 3'd4,
        ST_OBS_HOLD = 3'd5,
        ST_MUSIC    = 3'd6
    } state_e;

    typedef struct packed {
        logic fwd;
        logic back;
        logic left;
        logic right;
    } drive_t;

    function automatic logic is_drive(input logic [2:0] c);
        return (c >= CMD_FWD) && (c <= CMD_RIGHT);
    endfunction

    // Left/right turns are driven forward, so only CMD_BACK reverses the motor.
    function automatic drive_t manual_drive(input logic [2:0] c);
        drive_t d;
        d = '0;
        case (c)
            CMD_FWD:   d.fwd = 1'b1;
            CMD_BACK:  d.back = 1'b1;
            CMD_LEFT:  begin d.fwd = 1'b1; d.left = 1'b1; end
            CMD_RIGHT: begin d.fwd = 1'b1; d.right = 1'b1; end
            default:   d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/cycle_timer.sv
// Saturating up-counter shared by the entry, dead-time and obstacle-clear phases.
module cycle_timer #(
    parameter int CNT_W = 25
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             pause,
    input  logic [CNT_W-1:0] limit,
    output logic             done
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (!pause && (cnt != {CNT_W{1'b1}}))
            cnt <= cnt + 1'b1;
    end

    // done marks the last cycle of a limit-long phase, so the owner leaves on this edge.
    assign done = ({1'b0, cnt} + (CNT_W + 1)'(1)) >= {1'b0, limit};

endmodule

// File: rtl/drive_mode_arbiter.sv
// Arbitrates motor/steer drive between Bluetooth manual control, line tracking
// and obstacle holds; sequences the timed turn-in and the reversal dead-time.
module drive_mode_arbiter
    import car_pkg::*;
#(
    parameter int ENTRY_CYCLES = ENTRY_CYCLES_DEF,
    parameter int STOP_CYCLES  = STOP_CYCLES_DEF,
    parameter int CNT_W        = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] cmd,
    input  logic       trk_left,
    input  logic       trk_right,
    input  logic       trk_fwd,
    input  logic       obs_near,
    output logic       mot_fwd,
    output logic       mot_back,
    output logic       steer_left,
    output logic       steer_right,
    output logic       trk_en,
    output logic       music_en,
    output logic [2:0] state_o
);

    state_e           state, nxt_state;
    logic [2:0]       last_cmd, nxt_last;
    logic [2:0]       man_cmd, nxt_man;
    logic [2:0]       pend_cmd, nxt_pend;
    logic             cmd_new;
    logic             t_clear, t_pause, t_done;
    logic [CNT_W-1:0] t_limit;
    drive_t           md;

    // No timed state ever hands off directly to another, so holding the
    // counter at zero in every untimed state gives each phase a fresh start.
    always_comb begin
        t_clear = !(state inside {ST_DEADTIME, ST_ENTRY, ST_OBS_HOLD})
                  || (state == ST_OBS_HOLD && obs_near);
        t_pause = (state == ST_ENTRY) && obs_near;
        t_limit = (state == ST_ENTRY) ? CNT_W'(ENTRY_CYCLES) : CNT_W'(STOP_CYCLES);
    end

    cycle_timer #(.CNT_W(CNT_W)) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (t_clear),
        .pause (t_pause),
        .limit (t_limit),
        .done  (t_done)
    );

    always_comb begin
        nxt_state = state;
        nxt_last  = last_cmd;
        nxt_man   = man_cmd;
        nxt_pend  = pend_cmd;
        cmd_new   = (cmd != last_cmd);
        if (cmd_new && cmd == CMD_STOP) begin
            nxt_state = ST_IDLE;
            nxt_last  = cmd;
        end else begin
            case (state)
                ST_IDLE, ST_MUSIC, ST_MANUAL: begin
                    if (cmd_new) begin
                        nxt_last = cmd;
                        if (is_drive(cmd)) begin
                            if (state == ST_MANUAL
                                && ((cmd == CMD_BACK) != (man_cmd == CMD_BACK))) begin
                                nxt_state = ST_DEADTIME;
                                nxt_pend  = cmd;
                            end else begin
                                nxt_state = ST_MANUAL;
                                nxt_man   = cmd;
                            end
                        end else if (cmd == CMD_TRACK) begin
                            nxt_state = ST_ENTRY;
                        end else if (cmd == CMD_MUSIC) begin
                            nxt_state = ST_MUSIC;
                        end
                    end
                end
                ST_DEADTIME: begin
                    // Track/music requests stay unaccepted so they act once MANUAL is reached.
                    if (cmd_new && (is_drive(cmd) || cmd == CMD_NONE)) begin
                        nxt_last = cmd;
                        if (is_drive(cmd))
                            nxt_pend = cmd;
                    end
                    if (t_done) begin
                        nxt_state = ST_MANUAL;
                        nxt_man   = nxt_pend;
                    end
                end
                ST_ENTRY, ST_TRACK, ST_OBS_HOLD: begin
                    if (cmd_new)
                        nxt_last = cmd;
                    if (cmd_new && is_drive(cmd)) begin
                        nxt_state = ST_MANUAL;
                        nxt_man   = cmd;
                    end else if (state == ST_ENTRY) begin
                        if (t_done && !obs_near)
                            nxt_state = ST_TRACK;
                    end else if (state == ST_TRACK) begin
                        if (obs_near)
                            nxt_state = ST_OBS_HOLD;
                    end else if (t_done && !obs_near) begin
                        nxt_state = ST_TRACK;
                    end
                end
                default: nxt_state = ST_IDLE;
            endcase
        end
        md = manual_drive(nxt_man);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            last_cmd    <= CMD_NONE;
            man_cmd     <= CMD_NONE;
            pend_cmd    <= CMD_NONE;
            mot_fwd     <= 1'b0;
            mot_back    <= 1'b0;
            steer_left  <= 1'b0;
            steer_right <= 1'b0;
            trk_en      <= 1'b0;
            music_en    <= 1'b0;
        end else begin
            state       <= nxt_state;
            last_cmd    <= nxt_last;
            man_cmd     <= nxt_man;
            pend_cmd    <= nxt_pend;
            mot_fwd     <= 1'b0;
            mot_back    <= 1'b0;
            steer_left  <= 1'b0;
            steer_right <= 1'b0;
            trk_en      <= 1'b0;
            music_en    <= 1'b0;
            case (nxt_state)
                ST_MANUAL: begin
                    mot_fwd     <= md.fwd && !obs_near;
                    mot_back    <= md.back;
                    steer_left  <= md.left;
                    steer_right <= md.right;
                end
                ST_ENTRY: begin
                    mot_fwd     <= !obs_near;
                    steer_right <= 1'b1;
                end
                ST_TRACK: begin
                    trk_en      <= 1'b1;
                    mot_fwd     <= trk_fwd;
                    steer_left  <= trk_left && !trk_right;
                    steer_right <= trk_right && !trk_left;
                end
                ST_OBS_HOLD: trk_en   <= 1'b1;
                ST_MUSIC:    music_en <= 1'b1;
                default: ;
            endcase
        end
    end

    assign state_o = 3'(state);

    a_motor_excl: assert property (@(posedge clk) disable iff (rst) !(mot_fwd && mot_back));
    a_steer_excl: assert property (@(posedge clk) disable iff (rst) !(steer_left && steer_right));
    a_mode_excl:  assert property (@(posedge clk) disable iff (rst) !(trk_en && music_en));

endmodule

// File: tb/tb_drive_mode_arbiter.sv
// Directed scoreboard bench: the stimulus queues the expected outputs for each cycle,
// a negedge monitor pops and compares them against the DUT.
module tb_drive_mode_arbiter;
    import car_pkg::*;

    // Output vector order: {mot_fwd, mot_back, steer_left, steer_right, trk_en, music_en}
    localparam logic [5:0] Z   = 6'b000000;
    localparam logic [5:0] F   = 6'b100000;
    localparam logic [5:0] B   = 6'b010000;
    localparam logic [5:0] FL  = 6'b101000;
    localparam logic [5:0] FR  = 6'b100100;
    localparam logic [5:0] T   = 6'b000010;
    localparam logic [5:0] M   = 6'b000001;
    localparam logic [5:0] TFL = 6'b101010;

    typedef struct {
        string      nm;
        logic [5:0] o;
        logic [2:0] st;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] cmd;
    logic       trk_left, trk_right, trk_fwd, obs_near;
    logic       mot_fwd, mot_back, steer_left, steer_right, trk_en, music_en;
    logic [2:0] state_o;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;

    drive_mode_arbiter #(.ENTRY_CYCLES(8), .STOP_CYCLES(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .cmd(cmd),
        .trk_left(trk_left), .trk_right(trk_right), .trk_fwd(trk_fwd), .obs_near(obs_near),
        .mot_fwd(mot_fwd), .mot_back(mot_back), .steer_left(steer_left),
        .steer_right(steer_right), .trk_en(trk_en), .music_en(music_en), .state_o(state_o)
    );

    always #5 clk = ~clk;

    task automatic push(input string nm, input logic [5:0] o, input state_e s);
        exp_t e;
        e.nm = nm;
        e.o  = o;
        e.st = 3'(s);
        sb.push_back(e);
    endtask

    // Inputs set before the call are sampled on this edge; expectation is for the cycle after it.
    task automatic tick(input string nm, input logic [5:0] o, input state_e s);
        @(posedge clk);
        #1;
        push(nm, o, s);
    endtask

    initial begin : monitor
        exp_t       e;
        logic [5:0] act;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e   = sb.pop_front();
                act = {mot_fwd, mot_back, steer_left, steer_right, trk_en, music_en};
                n_chk++;
                if (act !== e.o || state_o !== e.st) begin
                    n_fail++;
                    $display("FAIL %s: got out=%b state=%0d, expected out=%b state=%0d",
                             e.nm, act, state_o, e.o, e.st);
                end
            end
        end
    end

    initial begin : stim
        rst = 1'b1; cmd = CMD_NONE;
        trk_left = 1'b0; trk_right = 1'b0; trk_fwd = 1'b0; obs_near = 1'b0;
        tick("reset", Z, ST_IDLE);
        rst = 1'b0;
        tick("idle", Z, ST_IDLE);

        // Reversal with dead-time; code 0 holds the current drive
        cmd = CMD_FWD;  tick("fwd", F, ST_MANUAL);
        cmd = CMD_NONE; tick("hold0", F, ST_MANUAL);
        cmd = CMD_BACK;
        for (int i = 0; i < 4; i++) tick("deadtime", Z, ST_DEADTIME);
        tick("back", B, ST_MANUAL);
        cmd = CMD_STOP; tick("stop1", Z, ST_IDLE);

        // Manual obstacle gating and steer-only change
        cmd = CMD_LEFT; obs_near = 1'b1; tick("left_obs", 6'b001000, ST_MANUAL);
        obs_near = 1'b0; tick("left_clr", FL, ST_MANUAL);
        cmd = CMD_RIGHT; tick("steer_chg", FR, ST_MANUAL);
        cmd = CMD_STOP; tick("stop2", Z, ST_IDLE);

        // Turn-in then tracking
        trk_left = 1'b1; trk_fwd = 1'b1; cmd = CMD_TRACK;
        for (int i = 0; i < 8; i++) tick("entry", FR, ST_ENTRY);
        tick("track", TFL, ST_TRACK);
        trk_right = 1'b1; tick("straight", 6'b100010, ST_TRACK);
        trk_right = 1'b0; tick("track2", TFL, ST_TRACK);

        // Obstacle hold: 3 near cycles then 4 clear samples
        obs_near = 1'b1;
        for (int i = 0; i < 3; i++) tick("obs_hold", T, ST_OBS_HOLD);
        obs_near = 1'b0;
        for (int i = 0; i < 3; i++) tick("obs_clear", T, ST_OBS_HOLD);
        tick("resume", TFL, ST_TRACK);

        // Glitch on clear sample 2 restarts the qualification
        obs_near = 1'b1; tick("g_enter", T, ST_OBS_HOLD);
        obs_near = 1'b0; tick("g_clr1", T, ST_OBS_HOLD);
        obs_near = 1'b1; tick("g_glitch", T, ST_OBS_HOLD);
        obs_near = 1'b0;
        for (int i = 0; i < 3; i++) tick("g_clear", T, ST_OBS_HOLD);
        tick("g_resume", TFL, ST_TRACK);

        // Manual takeover from tracking drops trk_en on the same edge
        cmd = CMD_RIGHT; tick("takeover", FR, ST_MANUAL);
        cmd = CMD_STOP;  tick("stop3", Z, ST_IDLE);

        // Entry paused by an obstacle: 3 + 5 paused + 5 = 13 cycles
        cmd = CMD_TRACK;
        for (int i = 0; i < 3; i++) tick("entry_a", FR, ST_ENTRY);
        obs_near = 1'b1;
        for (int i = 0; i < 5; i++) tick("entry_pause", 6'b000100, ST_ENTRY);
        obs_near = 1'b0;
        for (int i = 0; i < 5; i++) tick("entry_b", FR, ST_ENTRY);
        tick("entry_done", TFL, ST_TRACK);
        cmd = CMD_STOP; tick("stop4", Z, ST_IDLE);

        // Stop during dead-time and during entry
        cmd = CMD_FWD;  tick("fwd2", F, ST_MANUAL);
        cmd = CMD_BACK; tick("dt_a", Z, ST_DEADTIME);
        tick("dt_b", Z, ST_DEADTIME);
        cmd = CMD_STOP; tick("stop_dt", Z, ST_IDLE);
        cmd = CMD_TRACK; tick("entry_c", FR, ST_ENTRY);
        tick("entry_d", FR, ST_ENTRY);
        cmd = CMD_STOP; tick("stop_entry", Z, ST_IDLE);

        // Asynchronous reset mid-entry, seen before the next clock edge
        cmd = CMD_TRACK; tick("entry_e", FR, ST_ENTRY);
        tick("entry_f", FR, ST_ENTRY);
        @(posedge clk);
        #1;
        rst = 1'b1;
        push("async_rst", Z, ST_IDLE);
        cmd = CMD_NONE;
        #6;
        rst = 1'b0;
        tick("post_rst", Z, ST_IDLE);

        // Music and leaving it with a drive command
        cmd = CMD_MUSIC; tick("music", M, ST_MUSIC);
        cmd = CMD_FWD;   tick("music_fwd", F, ST_MANUAL);
        cmd = CMD_STOP;  tick("stop5", Z, ST_IDLE);

        for (int i = 0; i < 5 && sb.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (sb.size() > 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
